// File: rtl/pacman_pkg.sv
// Shared definitions for the Pac-Man playfield blocks.
// Holds the 3-bit direction codes produced by the direction controllers,
// the playfield geometry with the derived default position limits, and
// the state encoding of the grid_mover step FSM.
package pacman_pkg;

    // Direction codes; any code with bit 2 set means "hold".
    localparam logic [2:0] DIR_RIGHT = 3'b000;
    localparam logic [2:0] DIR_UP    = 3'b001;
    localparam logic [2:0] DIR_LEFT  = 3'b010;
    localparam logic [2:0] DIR_DOWN  = 3'b011;
    localparam logic [2:0] DIR_HOLD  = 3'b100;

    // Playfield geometry; positions are the top-left pixel of a sprite.
    localparam int FIELD_W     = 160;
    localparam int FIELD_H     = 120;
    localparam int SPRITE_SIZE = 5;

    localparam logic [7:0] X_MAX_DEF = 8'(FIELD_W - SPRITE_SIZE);
    localparam logic [6:0] Y_MAX_DEF = 7'(FIELD_H - SPRITE_SIZE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_COMMIT = 2'd2
    } mover_state_t;

endpackage

// File: rtl/grid_mover_if.sv
// Wall lookup handshake between a grid_mover and the maze wall table.
//   wall_req : query valid (mover -> lookup), held until wall_ack
//   wall_x   : queried cell x, stable while wall_req is high
//   wall_y   : queried cell y, stable while wall_req is high
//   wall_ack : response valid (lookup -> mover)
//   wall_hit : queried cell is a wall, qualified by wall_ack
// master = grid_mover side, slave = wall lookup side.
interface grid_mover_if;
    logic       wall_req;
    logic [7:0] wall_x;
    logic [6:0] wall_y;
    logic       wall_ack;
    logic       wall_hit;

    modport master (
        output wall_req,
        output wall_x,
        output wall_y,
        input  wall_ack,
        input  wall_hit
    );

    modport slave (
        input  wall_req,
        input  wall_x,
        input  wall_y,
        output wall_ack,
        output wall_hit
    );
endinterface

// File: rtl/grid_mover_step_tick_gen.sv
// step_tick_gen: free-running step-rate divider.
// Counts 0..TICK_DIV-1 and wraps; tick is high for the one cycle in which
// the count equals TICK_DIV-1. It never stops, whatever the consumer does.
//   clk     : system clock (rising edge)
//   reset_n : asynchronous active-low reset, clears the count
//   tick    : one-cycle step strobe
module step_tick_gen #(
    parameter int TICK_DIV = 2_500_000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int             CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/grid_mover.sv
// grid_mover: per-sprite position register and step engine.
// Once per step tick it takes the requested direction, works out the
// neighbouring cell, rejects it if it leaves the playfield, otherwise asks
// the wall lookup whether the cell is open and moves there if it is.
//   clk       : system clock (rising edge)
//   reset_n   : asynchronous active-low reset
//   dir_in    : requested direction (see pacman_pkg DIR_* codes)
//   reset_x/y : spawn position, static constants
//   wall      : wall lookup handshake (master side)
//   x_out/y_out : current position
//   step_done : one-cycle pulse, move committed
//   blocked   : one-cycle pulse, attempt rejected (bounds or wall)
module grid_mover
    import pacman_pkg::*;
#(
    parameter int         TICK_DIV = 2_500_000,
    parameter logic [7:0] X_MAX    = X_MAX_DEF,
    parameter logic [6:0] Y_MAX    = Y_MAX_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         dir_in,
    input  logic [7:0]         reset_x,
    input  logic [6:0]         reset_y,
    grid_mover_if.master       wall,
    output logic [7:0]         x_out,
    output logic [6:0]         y_out,
    output logic               step_done,
    output logic               blocked
);

    logic         tick;
    mover_state_t state_q, state_d;

    logic [7:0]   x_q, x_d;
    logic [6:0]   y_q, y_d;
    logic [7:0]   wall_x_q, wall_x_d;
    logic [6:0]   wall_y_q, wall_y_d;
    logic         step_done_q, step_done_d;
    logic         blocked_q, blocked_d;

    logic [7:0]   tgt_x;
    logic [6:0]   tgt_y;
    logic         tgt_oob;

    step_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    // Neighbour cell. The limit test happens before the +/-1 so the
    // unsigned arithmetic can never wrap.
    always_comb begin
        tgt_x   = x_q;
        tgt_y   = y_q;
        tgt_oob = 1'b0;
        case (dir_in)
            DIR_RIGHT: begin
                if (x_q == X_MAX) tgt_oob = 1'b1;
                else              tgt_x   = x_q + 8'd1;
            end
            DIR_UP: begin
                if (y_q == 7'd0)  tgt_oob = 1'b1;
                else              tgt_y   = y_q - 7'd1;
            end
            DIR_LEFT: begin
                if (x_q == 8'd0)  tgt_oob = 1'b1;
                else              tgt_x   = x_q - 8'd1;
            end
            DIR_DOWN: begin
                if (y_q == Y_MAX) tgt_oob = 1'b1;
                else              tgt_y   = y_q + 7'd1;
            end
            default: ;
        endcase
    end

    // Next-state logic. dir_in is only looked at on an IDLE tick, and the
    // resulting target is frozen in wall_x/wall_y for the rest of the
    // attempt; ticks and acks arriving in other states fall through.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        wall_x_d    = wall_x_q;
        wall_y_d    = wall_y_q;
        step_done_d = 1'b0;
        blocked_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick && !dir_in[2]) begin
                    if (tgt_oob) begin
                        blocked_d = 1'b1;
                    end else begin
                        wall_x_d = tgt_x;
                        wall_y_d = tgt_y;
                        state_d  = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (wall.wall_ack) begin
                    if (wall.wall_hit) begin
                        blocked_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        x_d         = wall_x_q;
                        y_d         = wall_y_q;
                        step_done_d = 1'b1;
                        state_d     = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            x_q         <= reset_x;
            y_q         <= reset_y;
            wall_x_q    <= '0;
            wall_y_q    <= '0;
            step_done_q <= 1'b0;
            blocked_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            wall_x_q    <= wall_x_d;
            wall_y_q    <= wall_y_d;
            step_done_q <= step_done_d;
            blocked_q   <= blocked_d;
        end
    end

    // wall_req decodes straight from the state register so an asynchronous
    // reset withdraws it in the same cycle.
    assign wall.wall_req = (state_q == ST_REQ);
    assign wall.wall_x   = wall_x_q;
    assign wall.wall_y   = wall_y_q;

    assign x_out     = x_q;
    assign y_out     = y_q;
    assign step_done = step_done_q;
    assign blocked   = blocked_q;

endmodule

// File: tb/tb_grid_mover.sv
module tb_grid_mover;
    import pacman_pkg::*;

    localparam int TICK_DIV = 4;

    logic       clk;
    logic       reset_n;
    logic [2:0] dir_in;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic       step_done;
    logic       blocked;

    grid_mover_if wall_bus ();

    grid_mover #(
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .dir_in    (dir_in),
        .reset_x   (8'd2),
        .reset_y   (7'd1),
        .wall      (wall_bus.master),
        .x_out     (x_out),
        .y_out     (y_out),
        .step_done (step_done),
        .blocked   (blocked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       is_step;
        logic [7:0] x;
        logic [6:0] y;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         total = 0;
    int         bad   = 0;
    logic [7:0] mx;
    logic [6:0] my;

    // Every step_done/blocked pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (step_done || blocked) begin
            total++;
            if (step_done && blocked) begin
                bad++;
                $display("FAIL pulse_overlap: step_done=%0b blocked=%0b, required not both", step_done, blocked);
            end else if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: step_done=%0b blocked=%0b pos=(%0d,%0d), required no pulse",
                         step_done, blocked, x_out, y_out);
            end else begin
                mon_e = sb.pop_front();
                if (step_done !== mon_e.is_step || x_out !== mon_e.x || y_out !== mon_e.y) begin
                    bad++;
                    $display("FAIL pulse_result: step=%0b pos=(%0d,%0d), required step=%0b pos=(%0d,%0d)",
                             step_done, x_out, y_out, mon_e.is_step, mon_e.x, mon_e.y);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n           = 1'b0;
        dir_in            = DIR_HOLD;
        wall_bus.wall_ack = 1'b0;
        wall_bus.wall_hit = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        mx      = 8'd2;
        my      = 7'd1;
    endtask

    // One step attempt: expectation pushed when dir is driven, ack given
    // 'delay' cycles after wall_req appears, dir_in switched to dir_during
    // while the request is outstanding.
    task automatic attempt(input logic [2:0] dir, input logic hit, input int delay,
                           input logic [2:0] dir_during);
        logic [7:0] tx;
        logic [6:0] ty;
        logic       oob;
        logic       seen;
        logic       req_seen;
        logic       stable;
        tx  = mx;
        ty  = my;
        oob = 1'b0;
        case (dir)
            DIR_RIGHT: if (mx == 8'd155) oob = 1'b1; else tx = mx + 8'd1;
            DIR_UP:    if (my == 7'd0)   oob = 1'b1; else ty = my - 7'd1;
            DIR_LEFT:  if (mx == 8'd0)   oob = 1'b1; else tx = mx - 8'd1;
            default:   if (my == 7'd115) oob = 1'b1; else ty = my + 7'd1;
        endcase
        if (oob)      sb.push_back('{1'b0, mx, my});
        else if (hit) sb.push_back('{1'b0, mx, my});
        else          sb.push_back('{1'b1, tx, ty});
        dir_in = dir;
        seen     = 1'b0;
        req_seen = 1'b0;
        if (oob) begin
            for (int n = 0; n < 8 && !seen; n++) begin
                @(negedge clk);
                if (wall_bus.wall_req) req_seen = 1'b1;
                if (blocked) seen = 1'b1;
            end
            dir_in = DIR_HOLD;
            total++;
            if (!seen) begin
                bad++;
                $display("FAIL oob_blocked_timeout: blocked=%0b, required 1 within 8 cycles", seen);
                void'(sb.pop_back());
            end
            total++;
            if (req_seen !== 1'b0) begin
                bad++;
                $display("FAIL oob_wall_req: wall_req seen=%0b, required 0", req_seen);
            end
        end else begin
            for (int n = 0; n < 8 && !seen; n++) begin
                @(negedge clk);
                if (wall_bus.wall_req) seen = 1'b1;
            end
            total++;
            if (!seen) begin
                bad++;
                $display("FAIL req_timeout: wall_req=%0b, required 1 within 8 cycles", seen);
                dir_in = DIR_HOLD;
                void'(sb.pop_back());
                return;
            end
            dir_in = dir_during;
            total++;
            if (wall_bus.wall_x !== tx || wall_bus.wall_y !== ty) begin
                bad++;
                $display("FAIL wall_target: got (%0d,%0d), required (%0d,%0d)",
                         wall_bus.wall_x, wall_bus.wall_y, tx, ty);
            end
            stable = 1'b1;
            for (int n = 0; n < delay; n++) begin
                @(negedge clk);
                if (wall_bus.wall_req !== 1'b1 || wall_bus.wall_x !== tx || wall_bus.wall_y !== ty)
                    stable = 1'b0;
            end
            if (delay > 0) begin
                total++;
                if (stable !== 1'b1) begin
                    bad++;
                    $display("FAIL req_stable: stable=%0b, required 1 over %0d cycles", stable, delay);
                end
            end
            wall_bus.wall_ack = 1'b1;
            wall_bus.wall_hit = hit;
            @(negedge clk);
            wall_bus.wall_ack = 1'b0;
            wall_bus.wall_hit = 1'b0;
            dir_in            = DIR_HOLD;
            total++;
            if (wall_bus.wall_req !== 1'b0) begin
                bad++;
                $display("FAIL req_drop: wall_req=%0b after ack, required 0", wall_bus.wall_req);
            end
            total++;
            if ((hit ? blocked : step_done) !== 1'b1) begin
                bad++;
                $display("FAIL ack_pulse: step_done=%0b blocked=%0b, required %s",
                         step_done, blocked, hit ? "blocked" : "step_done");
            end
            if (!hit) begin
                mx = tx;
                my = ty;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        total++;
        if (wall_bus.wall_req !== 1'b0 || wall_bus.wall_x !== 8'd0 || wall_bus.wall_y !== 7'd0) begin
            bad++;
            $display("FAIL reset_wall: req=%0b xy=(%0d,%0d), required 0 (0,0)",
                     wall_bus.wall_req, wall_bus.wall_x, wall_bus.wall_y);
        end
        total++;
        if (x_out !== 8'd2 || y_out !== 7'd1) begin
            bad++;
            $display("FAIL reset_pos: got (%0d,%0d), required (2,1)", x_out, y_out);
        end
        total++;
        if (step_done !== 1'b0 || blocked !== 1'b0) begin
            bad++;
            $display("FAIL reset_pulses: step_done=%0b blocked=%0b, required 0 0", step_done, blocked);
        end
        do_reset();
    endtask

    task automatic test_step_right();
        do_reset();
        attempt(DIR_RIGHT, 1'b0, 0, DIR_HOLD);
        total++;
        if (x_out !== 8'd3 || y_out !== 7'd1) begin
            bad++;
            $display("FAIL step_right_pos: got (%0d,%0d), required (3,1)", x_out, y_out);
        end
    endtask

    task automatic test_wall_hit();
        do_reset();
        attempt(DIR_RIGHT, 1'b1, 0, DIR_HOLD);
        total++;
        if (x_out !== 8'd2 || y_out !== 7'd1) begin
            bad++;
            $display("FAIL wall_hit_pos: got (%0d,%0d), required (2,1)", x_out, y_out);
        end
        // A fresh attempt only launches if the FSM went back to IDLE.
        attempt(DIR_DOWN, 1'b0, 2, DIR_HOLD);
        total++;
        if (x_out !== 8'd2 || y_out !== 7'd2) begin
            bad++;
            $display("FAIL after_hit_pos: got (%0d,%0d), required (2,2)", x_out, y_out);
        end
    endtask

    task automatic test_oob_up();
        do_reset();
        attempt(DIR_UP, 1'b0, 0, DIR_HOLD);
        attempt(DIR_UP, 1'b0, 0, DIR_HOLD);
        total++;
        if (x_out !== 8'd2 || y_out !== 7'd0) begin
            bad++;
            $display("FAIL oob_up_pos: got (%0d,%0d), required (2,0)", x_out, y_out);
        end
    endtask

    task automatic test_oob_right();
        do_reset();
        for (int i = 0; i < 153; i++) attempt(DIR_RIGHT, 1'b0, 0, DIR_HOLD);
        total++;
        if (x_out !== 8'd155) begin
            bad++;
            $display("FAIL walk_right_pos: x=%0d, required 155", x_out);
        end
        attempt(DIR_RIGHT, 1'b0, 0, DIR_HOLD);
        total++;
        if (x_out !== 8'd155 || y_out !== 7'd1) begin
            bad++;
            $display("FAIL oob_right_pos: got (%0d,%0d), required (155,1)", x_out, y_out);
        end
    endtask

    task automatic test_slow_ack();
        int steps;
        do_reset();
        attempt(DIR_LEFT, 1'b0, 10, DIR_HOLD);
        steps = 1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (step_done) steps++;
        end
        total++;
        if (steps !== 1 || x_out !== 8'd1 || y_out !== 7'd1) begin
            bad++;
            $display("FAIL slow_ack: steps=%0d pos=(%0d,%0d), required 1 (1,1)", steps, x_out, y_out);
        end
    endtask

    task automatic test_hold();
        int reqs;
        int pulses;
        logic [2:0] d;
        do_reset();
        reqs   = 0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            d      = 3'(i % 4);
            dir_in = 3'b100 | d;
            @(negedge clk);
            if (wall_bus.wall_req) reqs++;
            if (step_done || blocked) pulses++;
        end
        dir_in = DIR_HOLD;
        total++;
        if (reqs !== 0 || pulses !== 0) begin
            bad++;
            $display("FAIL hold: wall_req cycles=%0d pulses=%0d, required 0 0", reqs, pulses);
        end
        total++;
        if (x_out !== 8'd2 || y_out !== 7'd1) begin
            bad++;
            $display("FAIL hold_pos: got (%0d,%0d), required (2,1)", x_out, y_out);
        end
    endtask

    task automatic test_dir_change();
        do_reset();
        attempt(DIR_RIGHT, 1'b0, 3, DIR_DOWN);
        total++;
        if (x_out !== 8'd3 || y_out !== 7'd1) begin
            bad++;
            $display("FAIL dir_change_pos: got (%0d,%0d), required (3,1)", x_out, y_out);
        end
    endtask

    task automatic test_reset_mid_req();
        logic seen;
        int   reqs;
        int   pulses;
        do_reset();
        attempt(DIR_DOWN, 1'b0, 0, DIR_HOLD);
        // now at (2,2); launch another down move and abort it with reset
        dir_in = DIR_DOWN;
        seen   = 1'b0;
        for (int n = 0; n < 8 && !seen; n++) begin
            @(negedge clk);
            if (wall_bus.wall_req) seen = 1'b1;
        end
        dir_in = DIR_HOLD;
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL mid_req_launch: wall_req=%0b, required 1", seen);
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        total++;
        if (wall_bus.wall_req !== 1'b0 || wall_bus.wall_x !== 8'd0 || wall_bus.wall_y !== 7'd0) begin
            bad++;
            $display("FAIL mid_req_reset_wall: req=%0b xy=(%0d,%0d), required 0 (0,0)",
                     wall_bus.wall_req, wall_bus.wall_x, wall_bus.wall_y);
        end
        total++;
        if (x_out !== 8'd2 || y_out !== 7'd1 || step_done !== 1'b0 || blocked !== 1'b0) begin
            bad++;
            $display("FAIL mid_req_reset_pos: got (%0d,%0d) sd=%0b bl=%0b, required (2,1) 0 0",
                     x_out, y_out, step_done, blocked);
        end
        wall_bus.wall_ack = 1'b1;
        wall_bus.wall_hit = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        mx      = 8'd2;
        my      = 7'd1;
        reqs    = 0;
        pulses  = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (n == 2) wall_bus.wall_ack = 1'b0;
            if (wall_bus.wall_req) reqs++;
            if (step_done || blocked) pulses++;
        end
        total++;
        if (reqs !== 0 || pulses !== 0 || x_out !== 8'd2 || y_out !== 7'd1) begin
            bad++;
            $display("FAIL late_ack: reqs=%0d pulses=%0d pos=(%0d,%0d), required 0 0 (2,1)",
                     reqs, pulses, x_out, y_out);
        end
    endtask

    initial begin
        reset_n           = 1'b0;
        dir_in            = DIR_HOLD;
        wall_bus.wall_ack = 1'b0;
        wall_bus.wall_hit = 1'b0;
        mx                = 8'd2;
        my                = 7'd1;
        test_reset();
        test_step_right();
        test_wall_hit();
        test_oob_up();
        test_oob_right();
        test_slow_ack();
        test_hold();
        test_dir_change();
        test_reset_mid_req();
        repeat (4) @(negedge clk);
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d expected pulses never seen, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
